// File: rtl/shift_left_seq16.sv
`default_nettype none
// ============================================================================
// Module      : shift_left_seq16
// Description : Iterative logical shift-left unit. Shifts A left by B places,
//               one place per clock, then raises a one-cycle done pulse with
//               the result, the last bit shifted out and a sticky
//               sign-change (arithmetic overflow) flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_left_seq16 #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             overflow
);

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [SHW-1:0] count;

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore outputs. A zero shift skips SHIFT entirely.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (B != CNT_ZERO) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (count == CNT_ONE) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: load on an accepted start, shift one place per SHIFT cycle.
  // C, carry and overflow hold their values outside of those two cases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C        <= '0;
      count    <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            C        <= A;
            count    <= B;
            carry    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_SHIFT: begin
          C        <= {C[WIDTH-2:0], 1'b0};
          carry    <= C[WIDTH-1];
          overflow <= overflow | (C[WIDTH-1] ^ C[WIDTH-2]);
          count    <= count - CNT_ONE;
        end
        default: begin
          C <= C;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_left_seq16.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_left_seq16
// Description : Directed self-checking bench for shift_left_seq16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_left_seq16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [3:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] C;
  logic        carry;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;

  shift_left_seq16 #(.WIDTH(16), .SHW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .C        (C),
    .carry    (carry),
    .overflow (overflow)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge, wait (bounded) for done, check the latency in
  // edges counted from the start edge, then the results and return to idle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] b,
                        input logic [15:0] exp_c, input logic exp_carry,
                        input logic exp_ovf);
    int n;
    A     = a;
    B     = b;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      step();
      n++;
    end
    check({tag, "_done"},     {31'd0, done},     32'd1);
    check({tag, "_latency"},  n,                 b + 32'd1);
    check({tag, "_C"},        {16'd0, C},        {16'd0, exp_c});
    check({tag, "_carry"},    {31'd0, carry},    {31'd0, exp_carry});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    step();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"},      {31'd0, busy}, 32'd0);
    check({tag, "_C_hold"},    {16'd0, C},    {16'd0, exp_c});
  endtask

  initial begin : stim
    int  n;
    int  done_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    A     = 16'h0000;
    B     = 4'd0;

    // Reset state
    step();
    step();
    check("rst_C",        {16'd0, C},        32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_carry",    {31'd0, carry},    32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic shifts
    run_op("t1_0001_b4",  16'h0001, 4'd4,  16'h0010, 1'b0, 1'b0);
    run_op("t2_8001_b1",  16'h8001, 4'd1,  16'h0002, 1'b1, 1'b1);
    run_op("t3_1234_b0",  16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0);
    run_op("t4_FFFF_b15", 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b0);

    // Start while busy is ignored
    A     = 16'h00FF;
    B     = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    done_cnt = 0;
    step(); n++;
    step(); n++;
    A     = 16'h0001;
    B     = 4'd1;
    start = 1'b1;
    step(); n++;
    start = 1'b0;
    if (done) done_cnt++;
    while (!done && n < 40) begin
      step();
      n++;
      if (done) done_cnt++;
    end
    check("t5_done",     {31'd0, done},     32'd1);
    check("t5_latency",  n,                 32'd9);
    check("t5_C",        {16'd0, C},        32'h0000FF00);
    check("t5_carry",    {31'd0, carry},    32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("t5_done_once", done_cnt,   32'd1);
    check("t5_C_hold",    {16'd0, C}, 32'h0000FF00);

    // Asynchronous reset mid-operation
    A     = 16'h0F0F;
    B     = 4'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_C",        {16'd0, C},        32'd0);
    check("t6_rst_busy",     {31'd0, busy},     32'd0);
    check("t6_rst_done",     {31'd0, done},     32'd0);
    check("t6_rst_carry",    {31'd0, carry},    32'd0);
    check("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    check("t6_no_done_after_rst", done_cnt, 32'd0);
    run_op("t6_0003_b2", 16'h0003, 4'd2, 16'h000C, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
